// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Owns the fetch PC, issues word-aligned requests over a req/gnt interface,
// buffers in-order responses in a small circular queue and presents them to
// the datapath under valid/ready. A redirect flushes the queue and marks all
// responses still in flight as stale so they are dropped when they return.
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            mem_req,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            instr_valid,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    // count/outstanding/discard each range over 0..DEPTH; their sum needs one more bit
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [SW-1:0]   DEPTH_S  = SW'(DEPTH);
    localparam logic [PW-1:0]   LAST_PTR = PW'(DEPTH - 1);
    localparam logic [XLEN-1:0] WORD     = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_M  = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] head_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   discard;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [XLEN-1:0] q_data [DEPTH];

    logic [SW-1:0]   occupancy;
    logic [XLEN-1:0] redirect_base;
    logic            gnt_acc;
    logic            drop;
    logic            push;
    logic            pop;
    logic            head_valid;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Request only while every granted slot still has a queue entry reserved for it
    always_comb begin
        occupancy = {1'b0, count} + {1'b0, outstanding};
        mem_req   = !reset && !redirect && (occupancy < DEPTH_S);
    end

    assign mem_addr      = fetch_pc;
    assign redirect_base = redirect_pc & ALIGN_M;
    assign gnt_acc       = mem_req & mem_gnt;
    assign drop          = mem_rvalid && (discard != '0);
    assign push          = mem_rvalid && !drop && !redirect;
    assign head_valid    = (count != '0);
    assign instr_valid   = !reset && head_valid;
    assign pop           = instr_valid && instr_ready && !redirect;
    assign instr         = reset ? '0 : q_data[rd_ptr];
    assign instr_pc      = reset ? RESET_PC : head_pc;

    // PC, queue and in-flight bookkeeping; redirect overrides grant, push and pop
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            head_pc     <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_data[i] <= '0;
            end
        end else if (redirect) begin
            fetch_pc    <= redirect_base;
            head_pc     <= redirect_base;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            // everything still in flight after this edge is stale
            outstanding <= outstanding - CW'(mem_rvalid);
            discard     <= outstanding - CW'(mem_rvalid);
        end else begin
            if (gnt_acc) begin
                fetch_pc <= fetch_pc + WORD;
            end
            outstanding <= outstanding + CW'(gnt_acc) - CW'(mem_rvalid);
            if (drop) begin
                discard <= discard - CW'(1);
            end
            if (push) begin
                q_data[wr_ptr] <= mem_rdata;
                wr_ptr         <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr  <= ptr_inc(rd_ptr);
                head_pc <= head_pc + WORD;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a scoreboard.
// Scenario code pushes the expected (pc, instr) stream; a monitor pops and
// compares on every accepted instruction. A memory model answers grants in
// order after a programmable latency and checks the request address stream.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt = 1'b1;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready = 1'b1;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int lat = 1;
    logic [31:0] exp_addr = RPC;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    typedef struct {
        int          due;
        logic [31:0] data;
    } rsp_t;

    exp_t exp_q[$];
    rsp_t pend[$];

    fetch_unit #(.XLEN(32), .RESET_PC(RPC), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .instr_valid(instr_valid),
        .instr(instr),
        .instr_pc(instr_pc),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // memory contents: each word is its address with a fixed tag XORed in
    function automatic logic [31:0] fdat(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push_exp(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{pc: start + 32'(4 * i), data: fdat(start + 32'(4 * i))});
        end
    endtask

    // memory model: in-order responses lat cycles after grant, address check on grant
    always @(negedge clk) begin
        if (pend.size() != 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = pend[0].data;
            void'(pend.pop_front());
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
        end
        #2;
        if (reset) begin
            pend.delete();
        end else if (mem_req && mem_gnt) begin
            chk("mem_addr", mem_addr, exp_addr);
            pend.push_back('{due: cyc + lat, data: fdat(mem_addr)});
            exp_addr = exp_addr + 32'd4;
        end
    end

    // scoreboard monitor: every accepted instruction must match the queue head
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (!reset && !redirect && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none", instr_pc, instr);
            end else begin
                e = exp_q.pop_front();
                chk("instr_pc", instr_pc, e.pc);
                chk("instr", instr, e.data);
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
    endtask

    task automatic reset_dut(input int l, input logic rdy, input logic gnt);
        next_cycle();
        reset       = 1'b1;
        redirect    = 1'b0;
        lat         = l;
        instr_ready = rdy;
        mem_gnt     = gnt;
        exp_q.delete();
        exp_addr    = RPC;
        next_cycle();
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            next_cycle();
            #3;
            n++;
        end
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d left expected 0", name, exp_q.size());
        end
    endtask

    initial begin
        // reset state and steady stream
        reset_dut(1, 1'b1, 1'b1);
        #3;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_instr", instr, 0);
        chk("rst_instr_pc", instr_pc, RPC);
        push_exp(RPC, 8);
        next_cycle();
        reset = 1'b0;
        #3;
        chk("first_req", 32'(mem_req), 1);
        chk("first_addr", mem_addr, RPC);
        chk("lat_valid0", 32'(instr_valid), 0);
        next_cycle();
        #3;
        chk("lat_valid1", 32'(instr_valid), 0);
        next_cycle();
        #3;
        chk("lat_valid2", 32'(instr_valid), 1);
        chk("lat_pc2", instr_pc, RPC);
        drain("stream", 100);

        // backpressure: queue fills, requests stop, head frozen
        reset_dut(1, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b0;
        for (int k = 1; k < 8; k++) begin
            next_cycle();
            #3;
            if (k >= 3) begin
                chk("full_mem_req", 32'(mem_req), 0);
                chk("full_valid", 32'(instr_valid), 1);
                chk("full_pc", instr_pc, RPC);
                chk("full_instr", instr, 32'hC0DE_0100);
            end
        end
        push_exp(RPC, 8);
        next_cycle();
        instr_ready = 1'b1;
        drain("resume", 100);

        // grant stall: request held stable, PC does not advance
        reset_dut(1, 1'b1, 1'b0);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) next_cycle();
            #3;
            chk("stall_req", 32'(mem_req), 1);
            chk("stall_addr", mem_addr, RPC);
        end
        push_exp(RPC, 4);
        next_cycle();
        mem_gnt = 1'b1;
        drain("stall", 100);

        // redirect with two in flight (latency 3), back-to-back redirects
        reset_dut(3, 1'b1, 1'b1);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1FF0;
        #3;
        chk("redir_no_req", 32'(mem_req), 0);
        next_cycle();
        redirect_pc = 32'h0000_2003;
        exp_addr    = 32'h0000_2000;
        exp_q.delete();
        push_exp(32'h0000_2000, 4);
        #3;
        chk("redir2_no_req", 32'(mem_req), 0);
        next_cycle();
        redirect = 1'b0;
        #3;
        chk("redir_req", 32'(mem_req), 1);
        chk("redir_addr", mem_addr, 32'h0000_2000);
        drain("redirect", 100);

        // redirect coinciding with a response and a pop
        reset_dut(2, 1'b1, 1'b1);
        next_cycle();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        next_cycle();
        redirect    = 1'b1;
        redirect_pc = 32'h0000_3000;
        exp_addr    = 32'h0000_3000;
        exp_q.delete();
        push_exp(32'h0000_3000, 4);
        #3;
        chk("coin_valid", 32'(instr_valid), 1);
        chk("coin_pc", instr_pc, RPC);
        chk("coin_rvalid", 32'(mem_rvalid), 1);
        next_cycle();
        redirect = 1'b0;
        #3;
        chk("coin_empty", 32'(instr_valid), 0);
        chk("coin_req", 32'(mem_req), 1);
        chk("coin_addr", mem_addr, 32'h0000_3000);
        drain("coincide", 100);

        // reset mid-stream with the queue full
        reset_dut(1, 1'b0, 1'b1);
        next_cycle();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) next_cycle();
        #3;
        chk("pre_rst_valid", 32'(instr_valid), 1);
        next_cycle();
        reset = 1'b1;
        exp_q.delete();
        exp_addr = RPC;
        #3;
        chk("mid_rst_valid", 32'(instr_valid), 0);
        chk("mid_rst_req", 32'(mem_req), 0);
        next_cycle();
        #3;
        chk("post_rst_valid", 32'(instr_valid), 0);
        chk("post_rst_pc", instr_pc, RPC);
        chk("post_rst_instr", instr, 0);
        push_exp(RPC, 4);
        next_cycle();
        reset = 1'b0;
        instr_ready = 1'b1;
        #3;
        chk("restart_addr", mem_addr, RPC);
        drain("restart", 100);

        // address wrap, redirect in the first cycle out of reset, low bits ignored
        reset_dut(1, 1'b1, 1'b1);
        next_cycle();
        reset       = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFA;
        exp_addr    = 32'hFFFF_FFF8;
        push_exp(32'hFFFF_FFF8, 4);
        #3;
        chk("wrap_no_req", 32'(mem_req), 0);
        next_cycle();
        redirect = 1'b0;
        #3;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFF8);
        drain("wrap", 100);

        next_cycle();
        instr_ready = 1'b0;
        next_cycle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
